// File: rtl/bank_pkg.sv
// Shared types and widths for the register bank and its write-side controller.
package bank_pkg;

    localparam int unsigned REG_W  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        StEmpty,
        StDrain,
        StHold
    } wb_state_e;

endpackage

// File: rtl/bank_writer_if.sv
// Writeback result handshake between the ALU/memory stages and bank_writer.
interface bank_writer_if;
    import bank_pkg::*;

    logic              res_valid;
    logic [ADDR_W-1:0] res_addr;
    logic [REG_W-1:0]  res_data;
    logic              res_ready;

    modport master (
        output res_valid,
        output res_addr,
        output res_data,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_addr,
        input  res_data,
        output res_ready
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order circular queue of pending writebacks; exposes its contents oldest-first
// so the forwarding logic can search them without knowing the pointer layout.
module wb_fifo
    import bank_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head_entry,
    output logic [CNT_W-1:0]      count,
    output wb_entry_t [DEPTH-1:0] age_entries,
    output logic [DEPTH-1:0]      age_valid
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= push_entry;
        end
    end

    always_comb begin
        age_entries = '0;
        age_valid   = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            age_entries[k] = mem_q[head_q + PTR_W'(k)];
            age_valid[k]   = CNT_W'(k) < count_q;
        end
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/bank_writer.sv
// Write-side controller for the 32x32 register bank: queues writeback results,
// drains one per cycle onto the bank write port, and forwards pending values to reads.
module bank_writer
    import bank_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bank_writer_if.slave      res,
    input  logic              wb_stall,
    input  logic              flush,
    output logic [REG_W-1:0]  din,
    output logic [ADDR_W-1:0] wa,
    output logic              rw,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [REG_W-1:0]  bank_dr1,
    input  logic [REG_W-1:0]  bank_dr2,
    output logic [REG_W-1:0]  dr1,
    output logic [REG_W-1:0]  dr2
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]      count;
    wb_entry_t             head_entry;
    wb_entry_t             push_entry;
    wb_entry_t [DEPTH-1:0] age_entries;
    logic [DEPTH-1:0]      age_valid;
    wb_state_e             state;
    logic                  push, pop;

    logic [REG_W-1:0]  din_q, din_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic              rw_q, rw_d;

    // State is a pure decode of the registered occupancy and this cycle's stall.
    always_comb begin
        state = StEmpty;
        if (count != '0) begin
            state = wb_stall ? StHold : StDrain;
        end
    end

    // A full queue refuses pushes even when a pop would free a slot this cycle.
    assign res.res_ready = (count != CNT_W'(DEPTH)) && !flush;
    assign push          = res.res_valid && res.res_ready;
    assign pop           = (state == StDrain) && !flush;
    assign push_entry    = {res.res_addr, res.res_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head_entry  (head_entry),
        .count       (count),
        .age_entries (age_entries),
        .age_valid   (age_valid)
    );

    always_comb begin
        din_d = din_q;
        wa_d  = wa_q;
        rw_d  = 1'b0;
        case (state)
            StDrain: begin
                if (!flush) begin
                    din_d = head_entry.data;
                    wa_d  = head_entry.addr;
                    rw_d  = 1'b1;
                end
            end
            StEmpty, StHold: rw_d = 1'b0;
            default:         rw_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_q <= '0;
            wa_q  <= '0;
            rw_q  <= 1'b0;
        end else begin
            din_q <= din_d;
            wa_q  <= wa_d;
            rw_q  <= rw_d;
        end
    end

    assign din = din_q;
    assign wa  = wa_q;
    assign rw  = rw_q;

    // Queue entries are younger than the output stage, which is younger than the bank.
    function automatic logic [REG_W-1:0] fwd_read(
        input logic [ADDR_W-1:0]     ra,
        input logic [REG_W-1:0]      raw,
        input wb_entry_t [DEPTH-1:0] ents,
        input logic [DEPTH-1:0]      vld,
        input logic                  out_rw,
        input logic [ADDR_W-1:0]     out_wa,
        input logic [REG_W-1:0]      out_din
    );
        logic [REG_W-1:0] val;
        val = raw;
        if (out_rw && (out_wa == ra)) begin
            val = out_din;
        end
        // Oldest to youngest so the youngest matching entry is the one left standing.
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (vld[k] && (ents[k].addr == ra)) begin
                val = ents[k].data;
            end
        end
        return val;
    endfunction

    always_comb begin
        dr1 = fwd_read(ra1, bank_dr1, age_entries, age_valid, rw_q, wa_q, din_q);
        dr2 = fwd_read(ra2, bank_dr2, age_entries, age_valid, rw_q, wa_q, din_q);
    end

endmodule

// File: doc/bank_writer.md
# bank_writer

Write-side controller for the 32x32 register `bank`. It accepts writeback results from the ALU and memory stages through a valid/ready handshake and buffers them in a small in-order queue. It drains one entry per cycle onto the bank's `din`/`wa`/`rw` write port. It also forwards pending, not-yet-written values onto the two read ports, so the datapath never reads a stale register.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; must be a power of two, 2..16.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `res_valid`  in  1: writeback result offered.
- `res_addr`  in  5: destination register.
- `res_data`  in  32: result value.
- `res_ready`  out  1: result accepted when `res_valid && res_ready` at the edge.
- `wb_stall`  in  1: inhibit draining this cycle.
- `flush`  in  1: discard all queued entries.
- `din`  out  32: to `bank.din`.
- `wa`  out  5: to `bank.wa`.
- `rw`  out  1: to `bank.rw`; one-cycle write strobe.
- `ra1`, `ra2`  in  5: read addresses as presented to the bank.
- `bank_dr1`, `bank_dr2`  in  32: raw `bank.dr1`/`dr2`.
- `dr1`, `dr2`  out  32: forwarded read data (combinational).

## Operation
- Queue: circular buffer of {addr, data}, with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus `count` of log2(DEPTH)+1 bits.
- `res_ready = (count != DEPTH) && !flush`. A push while full is refused even if a pop happens in the same cycle.
- FSM states:
  - EMPTY (`count==0`).
  - DRAIN (`count>0`, `!wb_stall`).
  - HOLD (`count>0`, `wb_stall`).
  - State is derived from the registered `count` and `wb_stall` only.
- Pop occurs in DRAIN. At the edge, the head entry loads `din`/`wa`, `rw` is set to 1, and head and `count` advance. In EMPTY or HOLD, `rw` is cleared at the edge; `din`/`wa` hold their last value.
- Simultaneous push and pop: `count` is unchanged, and both pointers advance.
- `flush=1`: at the edge, head = tail = 0 and `count=0`, and any concurrent push is dropped (`res_ready=0`). A write already on `rw` in the flush cycle completes; `rw` is 0 after the edge.
- Forwarding, per read port independently. `dr1` takes the newest match in this priority order:
  - the youngest valid queue entry with addr == `ra1`;
  - otherwise the output stage (`rw==1 && wa==ra1`) returns `din`;
  - otherwise `bank_dr1`.
  - `dr2` is handled identically for `ra2`.
- All 32 addresses are writable, including 0; no address is special-cased.
- Duplicate addresses in the queue are legal and are written in order; the last write wins.

## Timing
- Reset values: `rw=0`, `din=0`, `wa=0`, `count=0`, head = tail = 0, `res_ready=1` on the first cycle after reset.
- Latency: a result accepted at edge N into an empty queue gives `rw=1` with its `wa`/`din` during cycle N+1..N+2. There is no push-to-pop bypass.
- Throughput: one write per cycle sustained.
- `rw` is high for exactly one cycle per popped entry. Back-to-back pops keep `rw` high continuously, with `wa`/`din` changing each cycle.
- A `wb_stall` asserted in cycle k means no pop at the end of k, so `rw=0` in k+1.
- Reset mid-drain: the queue is lost and `rw=0` on the next cycle. No partial write is issued.
- Forwarding paths are purely combinational: from `ra*`, the queue registers and the output stage to `dr*`.

## Structure
- Shared package `bank_pkg`: `REG_W=32`, `ADDR_W=5`, `NREGS=32`, and the `wb_entry_t` typedef {addr, data}.
- One sub-module: `wb_fifo`, a parameterized circular queue exposing head entry, count, and a flat view of entries with per-entry valid bits for the forward search.
- `bank_writer` holds the output stage, the FSM decode, and the two forward muxes (priority encoder from the tail backwards).

## Test plan
- Reset, then push (addr 5, 0x1234): `rw=1`, `wa=5`, `din=0x1234` one cycle after acceptance; the bank then reads 0x1234 at address 5.
- Push 4 results (addrs 1,2,3,4) with `wb_stall=1`: `res_ready=0` after the 4th, a 5th push is refused. Release the stall: 4 consecutive `rw` cycles in order 1,2,3,4.
- Queue addr 7 = 10 then addr 7 = 20 with the stall held, `ra1=7`: `dr1=20`. After the drain completes, `bank_dr1=20`.
- `ra2=9` with no pending entry and `bank_dr2=720`: `dr2=720`. With the output stage writing addr 9 = 55: `dr2=55`.
- Queue 3 entries, assert `flush` together with a valid push: push refused, `count=0` next cycle, no further `rw`.
- Drive `rst_n=0` mid-drain with 2 entries left: `rw=0`, `din=0`, `wa=0`, `res_ready=1` after the reset edge.
